// File: rtl/fta_bus_pkg.sv
// rtl/fta_bus_pkg.sv - FTA request/response bus types shared by initiators and targets
package fta_bus_pkg;

    typedef struct packed {
        logic [3:0] core;
        logic [2:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  padr;
        logic [127:0] data1;
        fta_tranid_t  tid;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         rty;
        fta_tranid_t  tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

// File: rtl/fta_resp_fifo.sv
// rtl/fta_resp_fifo.sv - response queue for FTA targets; head is valid whenever empty is low
module fta_resp_fifo
    import fta_bus_pkg::*;
#(
    parameter int FDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  fta_cmd_response128_t      push_data,
    input  logic                      pop,
    output fta_cmd_response128_t      head,
    output logic [$clog2(FDEPTH):0]   count,
    output logic                      empty
);

    localparam int AW = $clog2(FDEPTH);

    fta_cmd_response128_t mem [FDEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fta_sram_target.sv
// rtl/fta_sram_target.sv - 128-bit SRAM responder on the FTA bus with credit-based rty throttling
module fta_sram_target
    import fta_bus_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'hFFF8_0000,
    parameter int          ADRW   = 12,
    parameter int          RD_LAT = 2,
    parameter int          FDEPTH = 4,
    parameter bit          ACK_WR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  fta_cmd_request128_t  req,
    output fta_cmd_response128_t resp
);

    localparam int WORDS = 1 << ADRW;
    localparam int CW    = $clog2(FDEPTH) + 1;

    if (RD_LAT != 2) begin : g_rd_lat_check
        $error("fta_sram_target: only RD_LAT == 2 is implemented");
    end

    logic [127:0]         ram [WORDS];
    logic [127:0]         ram_q;
    logic [ADRW-1:0]      widx;
    logic                 hit;
    logic                 full;
    logic                 accept;
    logic                 enq;
    logic [CW:0]          occ;

    logic                 s1_v;
    logic                 s1_we;
    fta_tranid_t          s1_tid;
    logic [31:0]          s1_adr;
    logic                 s2_v;
    fta_cmd_response128_t s2_rsp;

    fta_cmd_response128_t fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    fta_cmd_response128_t resp_q;

    assign widx   = req.padr[ADRW+3:4];
    assign hit    = req.cyc && (req.padr[31:ADRW+4] == BASE[31:ADRW+4]);
    // Credit counts every response already committed to, so a later push always finds room.
    assign occ    = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
    assign full   = occ >= (CW+1)'(FDEPTH);
    assign accept = hit && !full;
    assign enq    = accept && (!req.we || ACK_WR);

    always_ff @(posedge clk) begin
        if (accept && req.we) begin
            for (int i = 0; i < 16; i++) begin
                if (req.sel[i])
                    ram[widx][8*i +: 8] <= req.data1[8*i +: 8];
            end
        end
        if (accept && !req.we)
            ram_q <= ram[widx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_we  <= 1'b0;
            s1_tid <= '0;
            s1_adr <= '0;
            s2_v   <= 1'b0;
            s2_rsp <= '0;
        end else begin
            s1_v <= enq;
            if (accept) begin
                s1_we  <= req.we;
                s1_tid <= req.tid;
                s1_adr <= req.padr;
            end
            s2_v       <= s1_v;
            s2_rsp.ack <= 1'b1;
            s2_rsp.rty <= 1'b0;
            s2_rsp.tid <= s1_tid;
            s2_rsp.adr <= s1_adr;
            s2_rsp.dat <= s1_we ? '0 : ram_q;
        end
    end

    fta_resp_fifo #(
        .FDEPTH (FDEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_v),
        .push_data (s2_rsp),
        .pop       (!fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_q <= '0;
        else if (!fifo_empty)
            resp_q <= fifo_head;
        else
            resp_q <= '0;
    end

    // rty is the only combinational response field; it must answer the request in its own cycle.
    always_comb begin
        resp     = resp_q;
        resp.rty = hit && full;
    end

endmodule

// File: tb/tb_fta_sram_target.sv
// tb/tb_fta_sram_target.sv - randomized self-checking bench for fta_sram_target
module tb_fta_sram_target;
    import fta_bus_pkg::*;

    localparam logic [31:0] BASE    = 32'hFFF8_0000;
    localparam logic [15:0] BASE_HI = 16'hFFF8;
    localparam int          NDUT    = 2;
    localparam int          MAXC    = 4096;

    logic clk = 1'b0;
    logic rst;
    fta_cmd_request128_t  req_d  [NDUT];
    fta_cmd_response128_t resp_d [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit gaps   = 1'b0;

    logic                 exp_v  [NDUT][MAXC];
    fta_cmd_response128_t exp_r  [NDUT][MAXC];
    logic                 inpipe [NDUT][MAXC];
    logic [127:0]         mem    [int];
    fta_cmd_request128_t  q      [NDUT][$];

    always #5 clk = ~clk;

    fta_sram_target #(
        .BASE(BASE), .ADRW(12), .RD_LAT(2), .FDEPTH(4), .ACK_WR(1'b1)
    ) u_dut_ack (
        .clk(clk), .rst(rst), .req(req_d[0]), .resp(resp_d[0])
    );

    fta_sram_target #(
        .BASE(BASE), .ADRW(12), .RD_LAT(2), .FDEPTH(2), .ACK_WR(1'b0)
    ) u_dut_posted (
        .clk(clk), .rst(rst), .req(req_d[1]), .resp(resp_d[1])
    );

    function automatic int fdepth_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic bit ackwr_of(input int d);
        return (d == 0);
    endfunction

    function automatic fta_cmd_request128_t mk(input bit we, input logic [31:0] adr, input logic [15:0] sel,
                                               input logic [127:0] dat, input logic [2:0] ch,
                                               input logic [3:0] tr);
        fta_cmd_request128_t r;
        r             = '0;
        r.cyc         = 1'b1;
        r.we          = we;
        r.sel         = sel;
        r.padr        = adr;
        r.data1       = dat;
        r.tid.core    = 4'd1;
        r.tid.channel = ch;
        r.tid.tranid  = tr;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < MAXC; c++) begin
                exp_v[d][c]  = 1'b0;
                inpipe[d][c] = 1'b0;
            end
            q[d].delete();
            req_d[d] = '0;
        end
    endtask

    // One bus cycle: drive queue heads, check the DUT against the model, then advance the model.
    task automatic step();
        fta_cmd_request128_t  r [NDUT];
        fta_cmd_response128_t e;
        int                   occ;
        int                   key;
        bit                   hit;
        bit                   full;
        logic [127:0]         m;
        if (cyc + 4 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        for (int d = 0; d < NDUT; d++) begin
            if (q[d].size() > 0 && (!gaps || $urandom_range(0, 3) != 0))
                r[d] = q[d][0];
            else
                r[d] = '0;
            req_d[d] = r[d];
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            occ = 0;
            for (int j = 1; j <= 3; j++)
                if (cyc - j >= 0 && inpipe[d][cyc-j])
                    occ++;
            hit  = r[d].cyc && (r[d].padr[31:16] == BASE_HI);
            full = occ >= fdepth_of(d);
            e    = exp_v[d][cyc] ? exp_r[d][cyc] : '0;
            e.rty = hit && full;
            check((d == 0) ? "resp_ackwr" : "resp_posted", 256'(resp_d[d]), 256'(e));
            if (r[d].cyc && !(hit && full))
                void'(q[d].pop_front());
            if (hit && !full) begin
                key = d * 4096 + int'(r[d].padr[15:4]);
                m   = mem.exists(key) ? mem[key] : '0;
                e   = '0;
                e.ack = 1'b1;
                e.tid = r[d].tid;
                e.adr = r[d].padr;
                if (r[d].we) begin
                    for (int i = 0; i < 16; i++)
                        if (r[d].sel[i])
                            m[8*i +: 8] = r[d].data1[8*i +: 8];
                    mem[key] = m;
                    e.dat    = '0;
                end else begin
                    e.dat = m;
                end
                if (!r[d].we || ackwr_of(d)) begin
                    inpipe[d][cyc]  = 1'b1;
                    exp_v[d][cyc+4] = 1'b1;
                    exp_r[d][cyc+4] = e;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_queues();
        int budget;
        budget = 2000;
        while ((q[0].size() > 0 || q[1].size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        check("queue_drain", 256'(budget > 0), 256'(1));
        if (budget == 0)
            clear_model();
        repeat (6) step();
    endtask

    task automatic init_words();
        mem.delete();
        gaps = 1'b0;
        for (int d = 0; d < NDUT; d++)
            for (int w = 0; w < 16; w++)
                q[d].push_back(mk(1'b1, BASE + 32'(w * 16), 16'hFFFF, rnd128(), 3'd0, 4'(w)));
        run_queues();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int kind;
        int w;
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check("reset_state", 256'(resp_d[d]), 256'(0));
        rst = 1'b0;
        cyc = 0;

        init_words();

        // Reset mid-burst: one ack already visible, two reads still in flight.
        gaps = 1'b0;
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 3; i++)
                q[d].push_back(mk(1'b0, BASE + 32'(16 * (i + 1)), 16'hFFFF, '0, 3'd2, 4'(i)));
        repeat (4) step();
        for (int d = 0; d < NDUT; d++)
            check("rst_pre_ack", 256'(resp_d[d].ack), 256'(1));
        clear_model();
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++)
            check("rst_async_zero", 256'(resp_d[d]), 256'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        repeat (8) step();

        init_words();

        // Write then read back; the posted-write DUT must produce only the read's ack.
        for (int d = 0; d < NDUT; d++) begin
            q[d].push_back(mk(1'b1, BASE + 32'h10, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                              3'd1, 4'd1));
            q[d].push_back(mk(1'b0, BASE + 32'h10, 16'hFFFF, '0, 3'd1, 4'd2));
        end
        run_queues();

        // Byte enables: only bytes 4..7 take the new value.
        for (int d = 0; d < NDUT; d++) begin
            q[d].push_back(mk(1'b1, BASE + 32'h20, 16'hFFFF, '0, 3'd1, 4'd3));
            q[d].push_back(mk(1'b1, BASE + 32'h20, 16'h00F0, {128{1'b1}}, 3'd1, 4'd4));
            q[d].push_back(mk(1'b1, BASE + 32'h30, 16'h0000, {128{1'b1}}, 3'd1, 4'd5));
            q[d].push_back(mk(1'b0, BASE + 32'h20, 16'hFFFF, '0, 3'd1, 4'd6));
            q[d].push_back(mk(1'b0, BASE + 32'h30, 16'hFFFF, '0, 3'd1, 4'd7));
        end
        run_queues();

        // Six back-to-back reads: the shallow DUT must throttle with rty and keep order.
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 6; i++)
                q[d].push_back(mk(1'b0, BASE + 32'(16 * i), 16'hFFFF, '0, 3'd3, 4'(i)));
        run_queues();

        // Misses below and above the window, each followed by a hit.
        for (int d = 0; d < NDUT; d++) begin
            q[d].push_back(mk(1'b0, BASE - 32'h10, 16'hFFFF, '0, 3'd4, 4'd0));
            q[d].push_back(mk(1'b0, BASE + 32'h40, 16'hFFFF, '0, 3'd4, 4'd1));
            q[d].push_back(mk(1'b1, BASE + 32'h1_0000, 16'hFFFF, rnd128(), 3'd4, 4'd2));
            q[d].push_back(mk(1'b0, BASE + 32'h50, 16'hFFFF, '0, 3'd4, 4'd3));
        end
        run_queues();

        // Random mix with idle gaps.
        gaps = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 120; i++) begin
                kind = $urandom_range(0, 9);
                w    = $urandom_range(0, 15);
                if (kind == 0)
                    q[d].push_back(mk(1'b0, BASE - 32'(16 * (w + 1)), 16'hFFFF, '0, 3'd5, 4'(i)));
                else if (kind <= 4)
                    q[d].push_back(mk(1'b1, BASE + 32'(16 * w) + 32'($urandom_range(0, 15)),
                                      16'($urandom), rnd128(), 3'd6, 4'(i)));
                else
                    q[d].push_back(mk(1'b0, BASE + 32'(16 * w) + 32'($urandom_range(0, 15)),
                                      16'hFFFF, '0, 3'd7, 4'(i)));
            end
        end
        run_queues();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
